student_apb_router: RTL and testbench

APB router and access sequencer between the SoC-side APB bus and up to NSLV student areas. It decodes the upstream address to one student window and replays the transfer downstream as a clean SETUP/ACCESS sequence. It bounds every access with a timeout, because a student slave may never assert PREADY. It also turns disabled, unmapped or timed-out accesses into upstream PSLVERR responses, so a faulty student area cannot hang the SoC bus.

---
 rtl/student_apb_pkg.sv | 15 +
 rtl/student_apb_router_if.sv | 28 ++
 rtl/student_apb_timeout.sv | 30 +++
 rtl/student_apb_router.sv | 199 +++++++++++++++++++
 tb/tb_student_apb_router.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/student_apb_pkg.sv
// rtl/student_apb_pkg.sv - shared types and constants for the student APB router
package student_apb_pkg;

  localparam int          IDX_W     = 4;
  localparam int          TO_CNT_W  = 16;
  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } router_state_e;

endpackage

// File: rtl/student_apb_router_if.sv
// rtl/student_apb_router_if.sv - upstream SoC-side APB bus seen by the router
interface student_apb_router_if #(
  parameter int SLV_AW = 12,
  parameter int APB_DW = 32
);
  import student_apb_pkg::*;

  logic [SLV_AW+IDX_W-1:0] PADDR;
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [APB_DW-1:0]       PWDATA;
  logic [APB_DW/8-1:0]     PSTRB;
  logic [APB_DW-1:0]       PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/student_apb_timeout.sv
// rtl/student_apb_timeout.sv - saturating ACCESS-cycle counter flagging the last allowed cycle
module student_apb_timeout
  import student_apb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != '1)) begin
      r_cnt <= r_cnt + TO_CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/student_apb_router.sv
// rtl/student_apb_router.sv - decodes SoC APB accesses to student windows and replays them downstream
module student_apb_router
  import student_apb_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int SLV_AW  = 12,
  parameter int APB_DW  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_in,
  input  logic                     rst,
  student_apb_router_if.slave      s_apb,
  output logic [SLV_AW-1:0]        m_paddr,
  output logic [APB_DW-1:0]        m_pwdata,
  output logic [APB_DW/8-1:0]      m_pstrb,
  output logic                     m_pwrite,
  output logic                     m_penable,
  output logic [NSLV-1:0]          m_psel,
  input  logic [NSLV*APB_DW-1:0]   m_prdata,
  input  logic [NSLV-1:0]          m_pready,
  input  logic [NSLV-1:0]          m_pslverr,
  input  logic [NSLV-1:0]          slv_en,
  output logic [NSLV-1:0]          to_flag,
  input  logic [NSLV-1:0]          to_clr,
  output logic                     irq
);

  localparam int SW = APB_DW / 8;

  router_state_e     r_state;
  router_state_e     w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [SLV_AW-1:0] r_addr;
  logic [APB_DW-1:0] r_wdata;
  logic [APB_DW-1:0] r_prdata;
  logic [SW-1:0]     r_strb;
  logic              r_write;
  logic              r_slverr;
  logic              r_irq;
  logic [NSLV-1:0]   r_flag;

  logic [IDX_W-1:0]  w_req_idx;
  logic              w_req;
  logic              w_req_ok;
  logic              w_sel_ready;
  logic              w_sel_err;
  logic [APB_DW-1:0] w_sel_rdata;
  logic              w_expire;
  logic              w_load;
  logic              w_capture;
  logic              w_err_resp;
  logic              w_to_set;
  logic [NSLV-1:0]   w_psel;
  logic [NSLV-1:0]   w_flag_set;
  logic              w_penable;
  logic              w_pready;
  logic              w_pslverr;

  assign w_req_idx = s_apb.PADDR[SLV_AW +: IDX_W];
  assign w_req     = s_apb.PSEL && s_apb.PENABLE && !w_pready;

  // Indices beyond NSLV never match, so they decode as disabled.
  always_comb begin
    w_req_ok    = 1'b0;
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (w_req_idx == IDX_W'(i)) begin
        w_req_ok = slv_en[i];
      end
      if (r_idx == IDX_W'(i)) begin
        w_sel_ready = m_pready[i];
        w_sel_err   = m_pslverr[i];
        w_sel_rdata = m_prdata[i*APB_DW +: APB_DW];
      end
    end
  end

  student_apb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_clear  (r_state == SETUP),
    .i_enable (r_state == ACCESS),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_capture  = 1'b0;
    w_err_resp = 1'b0;
    w_to_set   = 1'b0;
    w_psel     = '0;
    w_flag_set = '0;
    w_penable  = 1'b0;
    w_pready   = 1'b0;
    w_pslverr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_load     = 1'b1;
          w_err_resp = !w_req_ok;
          w_next     = w_req_ok ? SETUP : RESP;
        end
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        w_penable = 1'b1;
        // A ready on the final allowed cycle still completes normally.
        if (w_sel_ready) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end else if (w_expire) begin
          w_err_resp = 1'b1;
          w_to_set   = 1'b1;
          w_next     = RESP;
        end
      end
      RESP: begin
        w_pready  = 1'b1;
        w_pslverr = r_slverr;
        w_next    = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    for (int i = 0; i < NSLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_psel[i]     = (r_state == SETUP) || (r_state == ACCESS);
        w_flag_set[i] = w_to_set;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_idx    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_write  <= 1'b0;
      r_prdata <= '0;
      r_slverr <= 1'b0;
    end else begin
      if (w_load) begin
        r_idx   <= w_req_idx;
        r_addr  <= s_apb.PADDR[SLV_AW-1:0];
        r_wdata <= s_apb.PWDATA;
        r_strb  <= s_apb.PSTRB;
        r_write <= s_apb.PWRITE;
      end
      if (w_capture) begin
        r_prdata <= w_sel_rdata;
        r_slverr <= w_sel_err;
      end else if (w_err_resp) begin
        r_prdata <= APB_DW'(ERR_RDATA);
        r_slverr <= 1'b1;
      end
    end
  end

  // A timeout landing together with a clear keeps the flag set.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_flag <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_flag <= (r_flag & ~to_clr) | w_flag_set;
      r_irq  <= |r_flag;
    end
  end

  assign s_apb.PRDATA  = r_prdata;
  assign s_apb.PREADY  = w_pready;
  assign s_apb.PSLVERR = w_pslverr;
  assign m_paddr       = r_addr;
  assign m_pwdata      = r_wdata;
  assign m_pstrb       = r_strb;
  assign m_pwrite      = r_write;
  assign m_penable     = w_penable;
  assign m_psel        = w_psel;
  assign to_flag       = r_flag;
  assign irq           = r_irq;

endmodule

// File: tb/tb_student_apb_router.sv
// tb/tb_student_apb_router.sv - scoreboard bench for student_apb_router
module tb_student_apb_router;

  localparam int NSLV    = 4;
  localparam int SLV_AW  = 12;
  localparam int APB_DW  = 32;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] BAD = 32'hBADA_CCE5;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_in = ~clk_in;

  student_apb_router_if #(.SLV_AW(SLV_AW), .APB_DW(APB_DW)) apb ();

  logic [SLV_AW-1:0]      m_paddr;
  logic [APB_DW-1:0]      m_pwdata;
  logic [APB_DW/8-1:0]    m_pstrb;
  logic                   m_pwrite;
  logic                   m_penable;
  logic [NSLV-1:0]        m_psel;
  logic [NSLV*APB_DW-1:0] m_prdata;
  logic [NSLV-1:0]        m_pready;
  logic [NSLV-1:0]        m_pslverr;
  logic [NSLV-1:0]        slv_en;
  logic [NSLV-1:0]        to_flag;
  logic [NSLV-1:0]        to_clr;
  logic                   irq;

  student_apb_router #(
    .NSLV(NSLV), .SLV_AW(SLV_AW), .APB_DW(APB_DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .s_apb     (apb),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pstrb   (m_pstrb),
    .m_pwrite  (m_pwrite),
    .m_penable (m_penable),
    .m_psel    (m_psel),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .slv_en    (slv_en),
    .to_flag   (to_flag),
    .to_clr    (to_clr),
    .irq       (irq)
  );

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    int          psel_cyc;
    logic [3:0]  flags;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int          cur_idx;
  logic [11:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_strb;
  logic        cur_write;
  int          cfg_wait;
  logic [31:0] cfg_rdata;
  logic        cfg_err;
  logic [3:0]  m_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Downstream slaves: garbage everywhere except the selected slave during ACCESS.
  int acc;
  initial begin
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    acc       = 0;
    forever begin
      @(negedge clk_in);
      for (int i = 0; i < NSLV; i++) begin
        m_pready[i]                  = 1'($urandom);
        m_pslverr[i]                 = 1'($urandom);
        m_prdata[i*APB_DW +: APB_DW] = $urandom;
      end
      if (rst && m_penable && (m_psel != '0)) begin
        for (int i = 0; i < NSLV; i++) begin
          if (m_psel[i]) begin
            m_pready[i] = (cfg_wait >= 0) && (acc == cfg_wait);
            if (m_pready[i]) begin
              m_pslverr[i]                 = cfg_err;
              m_prdata[i*APB_DW +: APB_DW] = cfg_rdata;
            end
          end
        end
        acc++;
      end else begin
        acc = 0;
      end
    end
  end

  int   mon_waits;
  int   mon_psel;
  logic mon_bad;
  initial begin
    exp_t e;
    logic [3:0] exp_sel;
    mon_waits = 0;
    mon_psel  = 0;
    mon_bad   = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst) begin
        mon_waits = 0;
        mon_psel  = 0;
        mon_bad   = 1'b0;
      end else begin
        if (m_psel != '0) begin
          mon_psel++;
          exp_sel = 4'(1 << cur_idx);
          if (m_psel != exp_sel || m_paddr != cur_addr || m_pwdata != cur_wdata ||
              m_pstrb != cur_strb || m_pwrite != cur_write)
            mon_bad = 1'b1;
        end
        if (apb.PSEL && apb.PENABLE) begin
          if (apb.PREADY) begin
            if (sb_q.size() == 0) begin
              chk("unexpected_response", 32'(1), 32'(0));
            end else begin
              e = sb_q.pop_front();
              chk("prdata", apb.PRDATA, e.prdata);
              chk("pslverr", 32'(apb.PSLVERR), 32'(e.slverr));
              chk("wait_states", 32'(mon_waits), 32'(e.waits));
              chk("psel_cycles", 32'(mon_psel), 32'(e.psel_cyc));
              chk("shared_fields_stable", 32'(mon_bad), 32'(0));
              chk("to_flag", 32'(to_flag), 32'(e.flags));
              chk("irq", 32'(irq), 32'(e.irq));
            end
            mon_waits = 0;
            mon_psel  = 0;
            mon_bad   = 1'b0;
          end else begin
            mon_waits++;
          end
        end
      end
    end
  end

  // w < 0 means the slave never answers.
  task automatic do_xfer(input int idx, input logic [11:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int w,
                         input logic [31:0] rdata, input logic err);
    exp_t e;
    int   n;
    logic done;
    e.irq = |m_flags;
    if (idx >= NSLV || slv_en[idx] == 1'b0) begin
      e.prdata = BAD; e.slverr = 1'b1; e.waits = 1; e.psel_cyc = 0;
    end else if (w < 0 || w >= TIMEOUT) begin
      e.prdata = BAD; e.slverr = 1'b1; e.waits = TIMEOUT + 2; e.psel_cyc = TIMEOUT + 1;
      m_flags = m_flags | 4'(1 << idx);
    end else begin
      e.prdata = rdata; e.slverr = err; e.waits = 3 + w; e.psel_cyc = 2 + w;
    end
    e.flags = m_flags;
    sb_q.push_back(e);
    cur_idx = idx; cur_addr = addr; cur_wdata = wdata; cur_strb = strb; cur_write = wr;
    cfg_wait = w; cfg_rdata = rdata; cfg_err = err;
    @(posedge clk_in); #1;
    apb.PADDR   = {4'(idx), addr};
    apb.PWRITE  = wr;
    apb.PWDATA  = wdata;
    apb.PSTRB   = strb;
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    @(posedge clk_in); #1;
    apb.PENABLE = 1'b1;
    done = 1'b0;
    n    = 0;
    while (!done && n < 500) begin
      @(negedge clk_in);
      n++;
      if (apb.PREADY) done = 1'b1;
    end
    if (!done) begin
      chk("handshake_timeout", 32'(0), 32'(1));
      sb_q.delete();
    end
    @(posedge clk_in); #1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int          w;
    int          r;
    logic [3:0]  clr;
    apb.PADDR = '0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PWDATA = '0; apb.PSTRB = '0;
    slv_en = 4'hF; to_clr = '0; m_flags = '0;
    cur_idx = 0; cur_addr = '0; cur_wdata = '0; cur_strb = '0; cur_write = 1'b0;
    cfg_wait = 0; cfg_rdata = '0; cfg_err = 1'b0;

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_prdata", apb.PRDATA, 32'h0);
    chk("rst_ctrl", {27'h0, apb.PREADY, apb.PSLVERR, m_penable, m_pwrite, irq}, 32'h0);
    chk("rst_psel", 32'(m_psel), 32'h0);
    chk("rst_paddr", 32'(m_paddr), 32'h0);
    chk("rst_to_flag", 32'(to_flag), 32'h0);
    @(negedge clk_in);
    rst = 1'b1;

    do_xfer(1, 12'h000, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
    do_xfer(2, 12'h000, 1'b1, 32'hCAFE_F00D, 4'hF, 2, 32'h5555_AAAA, 1'b0);
    do_xfer(5, 12'h000, 1'b0, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0);
    slv_en = 4'b1110;
    do_xfer(0, 12'h000, 1'b0, 32'h0, 4'h0, 0, 32'h2222_2222, 1'b0);
    slv_en = 4'hF;

    do_xfer(3, 12'hABC, 1'b0, 32'h0, 4'h0, -1, 32'h3333_3333, 1'b0);
    chk("timeout_flag_held", 32'(to_flag), 32'h8);
    chk("timeout_irq", 32'(irq), 32'h1);
    to_clr = 4'b1000;
    @(posedge clk_in); #1;
    to_clr = '0;
    @(posedge clk_in); #1;
    m_flags = '0;
    chk("clr_flag", 32'(to_flag), 32'h0);
    chk("clr_irq", 32'(irq), 32'h0);

    to_clr = 4'b1000;
    do_xfer(3, 12'h044, 1'b1, 32'hDEAD_BEEF, 4'h3, -1, 32'h0, 1'b0);
    to_clr = '0;
    m_flags = '0;
    chk("clr_after_setwin", 32'(to_flag), 32'h0);

    do_xfer(1, 12'hFFF, 1'b0, 32'h0, 4'h0, TIMEOUT - 1, 32'h0BAD_F00D, 1'b1);

    cur_idx = 0; cur_addr = 12'h123; cur_wdata = 32'h0; cur_strb = 4'h0; cur_write = 1'b0;
    cfg_wait = 50;
    @(posedge clk_in); #1;
    apb.PADDR = {4'd0, 12'h123}; apb.PWRITE = 1'b0; apb.PWDATA = '0; apb.PSTRB = '0;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    @(posedge clk_in); #1;
    apb.PENABLE = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    chk("abort_psel_before", 32'({m_psel, m_penable}), 32'b0001_1);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_psel", 32'({m_psel, m_penable}), 32'h0);
    chk("abort_resp", 32'({apb.PREADY, apb.PSLVERR, irq}), 32'h0);
    chk("abort_prdata", apb.PRDATA, 32'h0);
    chk("abort_flags", 32'(to_flag), 32'h0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    m_flags = '0;
    @(negedge clk_in);
    rst = 1'b1;
    do_xfer(0, 12'h010, 1'b0, 32'h0, 4'h0, 1, 32'h7777_0000, 1'b0);

    for (int t = 0; t < 40; t++) begin
      slv_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      r = $urandom_range(0, 11);
      w = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
      do_xfer(int'($urandom_range(0, 5)), 12'($urandom), 1'($urandom), $urandom,
              4'($urandom), w, $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        clr = 4'($urandom);
        to_clr = clr;
        @(posedge clk_in); #1;
        to_clr = '0;
        m_flags = m_flags & ~clr;
      end
    end

    repeat (5) @(posedge clk_in);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
